// File: rtl/cmp_ctrl_pkg.sv
// Shared encodings and constants for the serial compare sequencer.
package cmp_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Cascade seed as {l, e, g}: "equal so far" before the lowest chunk.
    localparam logic [2:0] CASC_INIT = 3'b010;
    localparam int unsigned SLICE_W = 3;

endpackage

// File: rtl/cmp_slice3.sv
// 3-bit combinational magnitude compare slice with l/e/g cascade inputs.
// A local difference wins; on equality the cascade passes straight through.
module cmp_slice3
    import cmp_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] i_a,
    input  logic [SLICE_W-1:0] i_b,
    input  logic               i_l,
    input  logic               i_e,
    input  logic               i_g,
    output logic               o_lt,
    output logic               o_eq,
    output logic               o_gt
);

    always_comb begin
        o_lt = 1'b0;
        o_eq = 1'b0;
        o_gt = 1'b0;
        if (i_a > i_b) begin
            o_gt = 1'b1;
        end else if (i_a < i_b) begin
            o_lt = 1'b1;
        end else begin
            o_lt = i_l;
            o_eq = i_e;
            o_gt = i_g;
        end
    end

endmodule

// File: rtl/serial_cmp_sequencer.sv
// Wide compare done serially: one cmp_slice3 time-shared over WIDTH/3 steps, LSB chunk first.
// Define SERIAL_CMP_SIGNED_CMP_EN for two's-complement operands (sign-bias on the top chunk).
module serial_cmp_sequencer
    import cmp_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 12
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_lt,
    output logic             o_eq,
    output logic             o_gt
);

    localparam int unsigned NCHUNK = WIDTH / SLICE_W;
    localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (((WIDTH % SLICE_W) != 0) || (WIDTH < SLICE_W)) begin : g_bad_width
        $error("serial_cmp_sequencer: WIDTH must be a multiple of 3 and >= 3");
    end

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_idx, w_idx_nxt;
    logic [WIDTH-1:0] r_op_a, w_op_a_nxt;
    logic [WIDTH-1:0] r_op_b, w_op_b_nxt;
    logic [2:0]       r_casc, w_casc_nxt;  // {l, e, g}
    logic [2:0]       r_res, w_res_nxt;    // {lt, eq, gt}

    logic             w_last;
    logic [WIDTH-1:0] w_a_sh, w_b_sh;
    logic [SLICE_W-1:0] w_sl_a, w_sl_b;
    logic             w_sl_lt, w_sl_eq, w_sl_gt;

    assign w_last = (r_idx == CW'(NCHUNK - 1));
    assign w_a_sh = r_op_a >> (SLICE_W * r_idx);
    assign w_b_sh = r_op_b >> (SLICE_W * r_idx);

`ifdef SERIAL_CMP_SIGNED_CMP_EN
    // Flipping the sign bit of the top chunk maps two's complement onto unsigned order.
    assign w_sl_a = w_a_sh[SLICE_W-1:0] ^ {w_last, 2'b00};
    assign w_sl_b = w_b_sh[SLICE_W-1:0] ^ {w_last, 2'b00};
`else
    assign w_sl_a = w_a_sh[SLICE_W-1:0];
    assign w_sl_b = w_b_sh[SLICE_W-1:0];
`endif

    cmp_slice3 u_slice (
        .i_a  (w_sl_a),
        .i_b  (w_sl_b),
        .i_l  (r_casc[2]),
        .i_e  (r_casc[1]),
        .i_g  (r_casc[0]),
        .o_lt (w_sl_lt),
        .o_eq (w_sl_eq),
        .o_gt (w_sl_gt)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_op_a_nxt  = r_op_a;
        w_op_b_nxt  = r_op_b;
        w_casc_nxt  = r_casc;
        w_res_nxt   = r_res;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    w_state_nxt = ST_RUN;
                    w_op_a_nxt  = i_a;
                    w_op_b_nxt  = i_b;
                    w_idx_nxt   = '0;
                    w_casc_nxt  = CASC_INIT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                w_casc_nxt = {w_sl_lt, w_sl_eq, w_sl_gt};
                if (w_last) begin
                    w_res_nxt   = {w_sl_lt, w_sl_eq, w_sl_gt};
                    w_state_nxt = ST_DONE;
                end else begin
                    w_idx_nxt = r_idx + CW'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_casc  <= '0;
            r_res   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_op_a  <= w_op_a_nxt;
            r_op_b  <= w_op_b_nxt;
            r_casc  <= w_casc_nxt;
            r_res   <= w_res_nxt;
        end
    end

    // DONE always lasts exactly one cycle, so it doubles as the done pulse.
    assign o_busy = (r_state == ST_RUN);
    assign o_done = (r_state == ST_DONE);
    assign o_lt   = r_res[2];
    assign o_eq   = r_res[1];
    assign o_gt   = r_res[0];

endmodule

// File: tb/tb_serial_cmp_sequencer.sv
// Directed bench for serial_cmp_sequencer (WIDTH=12); expectations follow SERIAL_CMP_SIGNED_CMP_EN.
module tb_serial_cmp_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] a, b;
    logic        busy, done, lt, eq, gt;

    int vecs = 0;
    int errs = 0;

    localparam logic [2:0] R_LT = 3'b100;
    localparam logic [2:0] R_EQ = 3'b010;
    localparam logic [2:0] R_GT = 3'b001;
`ifdef SERIAL_CMP_SIGNED_CMP_EN
    localparam logic [2:0] EXP_FFF_001 = R_LT;
    localparam logic [2:0] EXP_800_7FF = R_LT;
`else
    localparam logic [2:0] EXP_FFF_001 = R_GT;
    localparam logic [2:0] EXP_800_7FF = R_GT;
`endif

    serial_cmp_sequencer #(.WIDTH(12)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .i_start (start),
        .i_a     (a),
        .i_b     (b),
        .o_busy  (busy),
        .o_done  (done),
        .o_lt    (lt),
        .o_eq    (eq),
        .o_gt    (gt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start one compare, check 4 busy cycles, the done pulse, result and hold.
    task automatic run_cmp(input logic [11:0] ta, input logic [11:0] tb_v,
                           input logic [2:0] exp, input string tag);
        @(negedge clk);
        a = ta;
        b = tb_v;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk({tag, "_busy"}, {6'd0, busy, done}, 8'b10);
        end
        @(negedge clk);
        chk({tag, "_done"}, {6'd0, busy, done}, 8'b01);
        chk({tag, "_res"}, {5'd0, lt, eq, gt}, {5'd0, exp});
        @(negedge clk);
        chk({tag, "_hold"}, {3'd0, busy, done, lt, eq, gt}, {3'd0, 2'b00, exp});
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;

        // 1: reset held, then released with no start
        repeat (2) @(negedge clk);
        chk("rst_held", {3'd0, busy, done, lt, eq, gt}, 8'd0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_idle", {3'd0, busy, done, lt, eq, gt}, 8'd0);
        end

        // 2-4: basic compares
        run_cmp(12'h5A3, 12'h5A3, R_EQ, "eq_5a3");
        run_cmp(12'h800, 12'h7FF, EXP_800_7FF, "top_chunk");
        run_cmp(12'h001, 12'h000, R_GT, "bot_chunk");
        run_cmp(12'hFFF, 12'h001, EXP_FFF_001, "fff_001");
        run_cmp(12'h123, 12'h456, R_LT, "lt_123");

        // 5a: start pulsed in RUN cycle 2 with new operands is ignored
        @(negedge clk);
        a = 12'h321;
        b = 12'h654;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a = 12'hFFF;
        b = 12'h000;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("ign_busy", {6'd0, busy, done}, 8'b10);
        end
        @(negedge clk);
        chk("ign_done", {6'd0, busy, done}, 8'b01);
        chk("ign_res", {5'd0, lt, eq, gt}, {5'd0, R_LT});
        @(negedge clk);
        chk("ign_idle", {6'd0, busy, done}, 8'b00);

        // 5b: start held through DONE -> back-to-back compare, no idle cycle
        a = 12'h300;
        b = 12'h200;
        start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("b2b_busy1", {6'd0, busy, done}, 8'b10);
        end
        a = 12'h111;
        b = 12'h222;
        @(negedge clk);
        chk("b2b_done1", {3'd0, busy, done, lt, eq, gt}, {3'd0, 2'b01, R_GT});
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("b2b_noidle", {3'd0, busy, done, lt, eq, gt}, {3'd0, 2'b10, R_GT});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("b2b_busy2", {6'd0, busy, done}, 8'b10);
        end
        @(negedge clk);
        chk("b2b_done2", {3'd0, busy, done, lt, eq, gt}, {3'd0, 2'b01, R_LT});

        // 6: reset at RUN cycle 2 aborts and clears outputs at once
        a = 12'h0AB;
        b = 12'h0AB;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_pre", {3'd0, busy, done, lt, eq, gt}, {3'd0, 2'b10, R_LT});
        #1 reset = 1'b1;
        #1 chk("abort_clr", {3'd0, busy, done, lt, eq, gt}, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort_nodone", {3'd0, busy, done, lt, eq, gt}, 8'd0);
        end
        run_cmp(12'h0AB, 12'h0AC, R_LT, "post_abort");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
